// File: rtl/object_pkg.sv
// Shared constants and descriptor type for the sprite-descriptor lookup.
// Group boundaries and base addresses describe the packed sprite-pixel ROM layout.
package object_pkg;

    localparam int NUM_OBJ = 36;
    localparam int ADDR_W  = 19;
    localparam int DIM_W   = 11;
    localparam int ID_W    = 6;

    localparam logic [ID_W-1:0] NUM_OBJ_ID = ID_W'(NUM_OBJ);
    localparam logic [ID_W-1:0] GRP1_ID    = 6'd10;
    localparam logic [ID_W-1:0] GRP2_ID    = 6'd18;
    localparam logic [ID_W-1:0] GRP3_ID    = 6'd30;
    localparam logic [ID_W-1:0] FG_ID      = 6'd34;
    localparam logic [ID_W-1:0] BG_ID      = 6'd35;

    localparam logic [ADDR_W-1:0] GRP0_BASE = 19'd0;
    localparam logic [ADDR_W-1:0] GRP1_BASE = 19'd2560;
    localparam logic [ADDR_W-1:0] GRP2_BASE = 19'd6656;
    localparam logic [ADDR_W-1:0] GRP3_BASE = 19'd9728;
    localparam logic [ADDR_W-1:0] FG_BASE   = 19'd13824;
    localparam logic [ADDR_W-1:0] BG_BASE   = 19'd15872;

    localparam logic [DIM_W-1:0] D16  = 11'd16;
    localparam logic [DIM_W-1:0] D32  = 11'd32;
    localparam logic [DIM_W-1:0] D64  = 11'd64;
    localparam logic [DIM_W-1:0] D480 = 11'd480;
    localparam logic [DIM_W-1:0] D640 = 11'd640;

    typedef struct packed {
        logic              valid;
        logic [DIM_W-1:0]  h;
        logic [DIM_W-1:0]  w;
        logic [ADDR_W-1:0] addr;
    } obj_desc_t;

    function automatic obj_desc_t mk_desc(input logic [DIM_W-1:0] h,
                                          input logic [DIM_W-1:0] w,
                                          input logic [ADDR_W-1:0] addr);
        obj_desc_t d;
        d.valid = 1'b1;
        d.h     = h;
        d.w     = w;
        d.addr  = addr;
        return d;
    endfunction

endpackage

// File: rtl/object_table_if.sv
// Id-in / descriptor-out bundle between scene logic (master) and the lookup (slave).
interface object_table_if;
    import object_pkg::*;

    logic [ID_W-1:0]   id;
    logic [DIM_W-1:0]  h;
    logic [DIM_W-1:0]  w;
    logic [ADDR_W-1:0] addr;
    logic              valid;

    modport master (output id, input h, w, addr, valid);
    modport slave  (input id, output h, w, addr, valid);

endinterface

// File: rtl/object_size_rom.sv
// Combinational id -> sprite descriptor decode; ids past the table return all zeros.
module object_size_rom
    import object_pkg::*;
(
    input  logic [ID_W-1:0] id_i,
    output obj_desc_t       desc_o
);

    // Within a group all sprites share a size, so the offset is a shift of the group index.
    always_comb begin
        desc_o = '0;
        if (id_i < GRP1_ID) begin
            desc_o = mk_desc(D16, D16, GRP0_BASE + (ADDR_W'(id_i) << 8));
        end else if (id_i < GRP2_ID) begin
            desc_o = mk_desc(D32, D16, GRP1_BASE + (ADDR_W'(id_i - GRP1_ID) << 9));
        end else if (id_i < GRP3_ID) begin
            desc_o = mk_desc(D16, D16, GRP2_BASE + (ADDR_W'(id_i - GRP2_ID) << 8));
        end else if (id_i < FG_ID) begin
            desc_o = mk_desc(D32, D32, GRP3_BASE + (ADDR_W'(id_i - GRP3_ID) << 10));
        end else if (id_i == FG_ID) begin
            desc_o = mk_desc(D32, D64, FG_BASE);
        end else if (id_i == BG_ID) begin
            desc_o = mk_desc(D480, D640, BG_BASE);
        end
    end

endmodule

// File: rtl/object_table.sv
// Registered sprite-descriptor lookup: one-cycle latency, new id accepted every cycle.
module object_table
    import object_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    object_table_if.slave  bus
);

    obj_desc_t desc_d;
    obj_desc_t desc_q;

    object_size_rom u_rom (
        .id_i   (bus.id),
        .desc_o (desc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_q <= '0;
        end else begin
            desc_q <= desc_d;
        end
    end

    assign bus.h     = desc_q.h;
    assign bus.w     = desc_q.w;
    assign bus.addr  = desc_q.addr;
    assign bus.valid = desc_q.valid;

endmodule

// File: tb/tb_object_table.sv
// Directed bench for object_table: packing-rule model checked every cycle plus literal spot checks.
module tb_object_table;
    import object_pkg::*;

    logic clk;
    logic rst_n;
    object_table_if bus ();

    object_table dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int exp_w, exp_h, exp_a, exp_v;
    int cap_w [NUM_OBJ];
    int cap_h [NUM_OBJ];
    int cap_a [NUM_OBJ];

    // Sprite size straight from the descriptor table.
    function automatic void sprite_dims(input int i, output int w, output int h);
        if (i < 10)       begin w = 16;  h = 16;  end
        else if (i < 18)  begin w = 16;  h = 32;  end
        else if (i < 30)  begin w = 16;  h = 16;  end
        else if (i < 34)  begin w = 32;  h = 32;  end
        else if (i == 34) begin w = 64;  h = 32;  end
        else              begin w = 640; h = 480; end
    endfunction

    // Base address comes from back-to-back packing of every earlier sprite.
    function automatic void ref_desc(input int i, output int w, output int h,
                                     output int a, output int v);
        int wj, hj;
        w = 0; h = 0; a = 0; v = 0;
        if (i >= 0 && i < NUM_OBJ) begin
            for (int j = 0; j < i; j++) begin
                sprite_dims(j, wj, hj);
                a += wj * hj;
            end
            sprite_dims(i, w, h);
            v = 1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_w = 0; exp_h = 0; exp_a = 0; exp_v = 0;
        end else begin
            ref_desc(int'(bus.id), exp_w, exp_h, exp_a, exp_v);
        end
    end

    task automatic chk(input string name, input int aw, input int ah, input int aa,
                       input int av, input int ew, input int eh, input int ea, input int ev);
        n_vec++;
        if (aw != ew || ah != eh || aa != ea || av != ev) begin
            n_miss++;
            $display("FAIL %s: got w=%0d h=%0d addr=%0d valid=%0d, want w=%0d h=%0d addr=%0d valid=%0d",
                     name, aw, ah, aa, av, ew, eh, ea, ev);
        end
    endtask

    task automatic chk_dut(input string name, input int ew, input int eh, input int ea, input int ev);
        chk(name, int'(bus.w), int'(bus.h), int'(bus.addr), int'(bus.valid), ew, eh, ea, ev);
    endtask

    always @(negedge clk) begin
        chk_dut("model", exp_w, exp_h, exp_a, exp_v);
    end

    task automatic step(input int v);
        @(negedge clk);
        bus.id = ID_W'(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mw, mh, ma, mv;
        rst_n  = 1'b0;
        bus.id = 6'd12;

        ref_desc(35, mw, mh, ma, mv);
        chk("model_bg", mw, mh, ma, mv, 640, 480, 15872, 1);
        chk("model_total", 0, 0, ma + mw * mh, 0, 0, 0, 323072, 0);
        ref_desc(40, mw, mh, ma, mv);
        chk("model_oob", mw, mh, ma, mv, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk_dut("reset_hold", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_dut("first_after_reset", 16, 32, 3584, 1);

        for (int i = 0; i < NUM_OBJ; i++) begin
            step(i);
            cap_w[i] = int'(bus.w);
            cap_h[i] = int'(bus.h);
            cap_a[i] = int'(bus.addr);
            case (i)
                9:  chk_dut("id9", 16, 16, 2304, 1);
                18: chk_dut("id18", 16, 16, 6656, 1);
                33: chk_dut("id33", 32, 32, 12800, 1);
                35: chk_dut("id35", 640, 480, 15872, 1);
                default: ;
            endcase
        end

        for (int i = 1; i < NUM_OBJ; i++) begin
            chk($sformatf("contig%0d", i), 0, 0, cap_a[i], 0,
                0, 0, cap_a[i-1] + cap_w[i-1] * cap_h[i-1], 0);
        end

        step(0);
        chk_dut("wrap_to_0", 16, 16, 0, 1);

        step(36);
        chk_dut("invalid36", 0, 0, 0, 0);
        step(63);
        chk_dut("invalid63", 0, 0, 0, 0);
        step(34);
        chk_dut("id34", 64, 32, 13824, 1);

        step(35);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_dut("async_clear", 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_dut("async_recover", 640, 480, 15872, 1);

        step(17);
        chk_dut("id17", 16, 32, 6144, 1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
